sqrt_stream: RTL and testbench

SQRT_STREAM -- requirements
Module: sqrt_stream

---
 rtl/sqrt_stream_if.sv | 25 ++
 rtl/sqrt_stream.sv | 157 +++++++++++++++
 tb/tb_sqrt_stream.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_stream_if.sv
// Handshake bundle for the streaming fixed-point square-root unit.
// The producer/consumer side uses master; the sqrt_stream block uses slave.
interface sqrt_stream_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] rad;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] root;
   logic [WIDTH:0]   rem;
   logic             err;

   modport master (
      output in_valid, rad, abort, out_ready,
      input  in_ready, out_valid, root, rem, err
   );

   modport slave (
      input  in_valid, rad, abort, out_ready,
      output in_ready, out_valid, root, rem, err
   );
endinterface

// File: rtl/sqrt_stream.sv
// Streaming fixed-point square root: root = floor(sqrt(rad * 2^FRAC_BITS)).
// Restoring digit recurrence, BITS_PER_CYCLE root bits per clock, with a
// one-cycle fast path for zero and (when SIGNED) negative radicands.
module sqrt_stream #(
   parameter int WIDTH          = 16,
   parameter int FRAC_BITS      = 8,
   parameter int BITS_PER_CYCLE = 1,
   parameter int SIGNED         = 0
) (
   input  logic         clk,
   input  logic         rst,
   sqrt_stream_if.slave s
);
   localparam int N     = WIDTH + FRAC_BITS;
   localparam int ITER  = N / 2;
   localparam int STEPS = ITER / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(STEPS + 1);
   localparam int AW    = WIDTH + 2;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state, state_n;
   logic [CNT_W-1:0]        cnt, cnt_n;
   logic [N-1:0]            sr, sr_n, sr_w;
   logic [AW-1:0]           acc, acc_n, acc_w;
   logic [WIDTH-1:0]        q, q_n, q_w;
   logic                    fast, fast_n;
   logic [WIDTH-1:0]        root_r, root_n;
   logic [WIDTH:0]          rem_r, rem_n;
   logic                    err_r, err_n;
   logic signed [WIDTH-1:0] rad_s;
   logic signed [WIDTH-1:0] held_s;
   logic                    rad_neg;
   logic                    held_neg;

   // One restoring step: bring down the next radicand bit pair, try to
   // subtract (4q+1), keep the difference and set the root bit if it fits.
   // The partial remainder never exceeds 2*root, so AW bits cannot overflow.
   function automatic logic [WIDTH+AW-1:0] rec_step(
      input logic [WIDTH-1:0] q_i,
      input logic [AW-1:0]    acc_i,
      input logic [1:0]       pair
   );
      logic [AW-1:0] a;
      logic [AW-1:0] t;
      a = (acc_i << 2) | AW'(pair);
      t = {q_i, 2'b01};
      if (a >= t) rec_step = {(q_i << 1) | WIDTH'(1), a - t};
      else        rec_step = {q_i << 1, a};
   endfunction

   assign rad_s    = s.rad;
   assign held_s   = sr[N-1 -: WIDTH];
   assign rad_neg  = (SIGNED != 0) && (rad_s < 0);
   assign held_neg = (SIGNED != 0) && (held_s < 0);

   // Unrolled recurrence for the bits resolved in one clock.
   always_comb begin
      q_w   = q;
      acc_w = acc;
      sr_w  = sr;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         {q_w, acc_w} = rec_step(q_w, acc_w, sr_w[N-1 -: 2]);
         sr_w = sr_w << 2;
      end
   end

   // Next-state and next-register decode for the IDLE -> RUN -> DONE loop.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sr_n    = sr;
      acc_n   = acc;
      q_n     = q;
      fast_n  = fast;
      root_n  = root_r;
      rem_n   = rem_r;
      err_n   = err_r;
      case (state)
         IDLE: begin
            if (s.in_valid) begin
               sr_n                 = '0;
               sr_n[N-1 -: WIDTH]   = s.rad;
               acc_n                = '0;
               q_n                  = '0;
               cnt_n                = '0;
               root_n               = '0;
               rem_n                = '0;
               err_n                = 1'b0;
               fast_n               = rad_neg || (s.rad == '0);
               state_n              = RUN;
            end
         end
         RUN: begin
            if (s.abort) begin
               state_n = IDLE;
               cnt_n   = '0;
               fast_n  = 1'b0;
            end else if (fast) begin
               // Zero or rejected radicand: result is known, spend one cycle.
               state_n = DONE;
               root_n  = '0;
               rem_n   = '0;
               err_n   = held_neg;
               fast_n  = 1'b0;
            end else begin
               acc_n = acc_w;
               q_n   = q_w;
               sr_n  = sr_w;
               cnt_n = cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  state_n = DONE;
                  root_n  = q_w;
                  rem_n   = acc_w[WIDTH:0];
                  err_n   = 1'b0;
               end
            end
         end
         DONE: begin
            if (s.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State, counter, datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         sr     <= '0;
         acc    <= '0;
         q      <= '0;
         fast   <= 1'b0;
         root_r <= '0;
         rem_r  <= '0;
         err_r  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         sr     <= sr_n;
         acc    <= acc_n;
         q      <= q_n;
         fast   <= fast_n;
         root_r <= root_n;
         rem_r  <= rem_n;
         err_r  <= err_n;
      end
   end

   assign s.in_ready  = (state == IDLE);
   assign s.out_valid = (state == DONE);
   assign s.root      = root_r;
   assign s.rem       = rem_r;
   assign s.err       = err_r;
endmodule

// File: tb/tb_sqrt_stream.sv
// Directed bench for sqrt_stream: default, two-bits-per-cycle and signed builds.
module tb_sqrt_stream;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   lat;
   logic seen;

   always #5 clk = ~clk;

   sqrt_stream_if #(.WIDTH(16)) d_if ();
   sqrt_stream_if #(.WIDTH(16)) b2_if ();
   sqrt_stream_if #(.WIDTH(16)) sg_if ();

   sqrt_stream u_d (.clk(clk), .rst(rst), .s(d_if));
   sqrt_stream #(.BITS_PER_CYCLE(2)) u_b2 (.clk(clk), .rst(rst), .s(b2_if));
   sqrt_stream #(.SIGNED(1)) u_sg (.clk(clk), .rst(rst), .s(sg_if));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic ov_of(input int sel);
      case (sel)
         0:       return d_if.out_valid;
         1:       return b2_if.out_valid;
         default: return sg_if.out_valid;
      endcase
   endfunction

   function automatic logic ir_of(input int sel);
      case (sel)
         0:       return d_if.in_ready;
         1:       return b2_if.in_ready;
         default: return sg_if.in_ready;
      endcase
   endfunction

   function automatic logic [15:0] root_of(input int sel);
      case (sel)
         0:       return d_if.root;
         1:       return b2_if.root;
         default: return sg_if.root;
      endcase
   endfunction

   function automatic logic [16:0] rem_of(input int sel);
      case (sel)
         0:       return d_if.rem;
         1:       return b2_if.rem;
         default: return sg_if.rem;
      endcase
   endfunction

   function automatic logic err_of(input int sel);
      case (sel)
         0:       return d_if.err;
         1:       return b2_if.err;
         default: return sg_if.err;
      endcase
   endfunction

   // Offer r at the next edge (edge 0) and return the edge number at which
   // out_valid is first seen, or -1 if it never shows within 40 edges.
   task automatic run_op(input int sel, input logic [15:0] r, input logic ab, output int l);
      case (sel)
         0:       begin d_if.in_valid = 1'b1;  d_if.rad = r;  d_if.abort = ab; end
         1:       begin b2_if.in_valid = 1'b1; b2_if.rad = r; end
         default: begin sg_if.in_valid = 1'b1; sg_if.rad = r; end
      endcase
      step();
      d_if.in_valid  = 1'b0;
      d_if.abort     = 1'b0;
      b2_if.in_valid = 1'b0;
      sg_if.in_valid = 1'b0;
      l = -1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (ov_of(sel)) begin
            l = k;
            break;
         end
      end
   endtask

   // Check a completed result, then let the hand-off edge pass (out_ready=1).
   task automatic chk_res(input string tag, input int sel, input int l, input int l_exp,
                          input logic [15:0] rt, input logic [16:0] rm, input logic e);
      chk({tag, "_lat"},  l, l_exp);
      chk({tag, "_root"}, root_of(sel), rt);
      chk({tag, "_rem"},  rem_of(sel), rm);
      chk({tag, "_err"},  err_of(sel), e);
      chk({tag, "_busy"}, ir_of(sel), 1'b0);
      step();
      chk({tag, "_ready"}, ir_of(sel), 1'b1);
      chk({tag, "_drop"},  ov_of(sel), 1'b0);
   endtask

   task automatic expect_silence(input string tag);
      seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         step();
         if (d_if.out_valid) seen = 1'b1;
      end
      chk(tag, seen, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      d_if.in_valid = 0;  d_if.rad = '0;  d_if.abort = 0;  d_if.out_ready = 1;
      b2_if.in_valid = 0; b2_if.rad = '0; b2_if.abort = 0; b2_if.out_ready = 1;
      sg_if.in_valid = 0; sg_if.rad = '0; sg_if.abort = 0; sg_if.out_ready = 1;
      repeat (2) @(negedge clk);
      chk("rst_ov",   d_if.out_valid, 1'b0);
      chk("rst_root", d_if.root, 16'h0);
      chk("rst_rem",  d_if.rem, 17'h0);
      chk("rst_err",  d_if.err, 1'b0);
      rst = 1'b0;
      step();
      chk("rst_ready", d_if.in_ready, 1'b1);

      // Default build, several radicands.
      run_op(0, 16'h0400, 1'b0, lat); chk_res("d_4p0",  0, lat, 12, 16'h0200, 17'h00000, 1'b0);
      run_op(0, 16'h0200, 1'b0, lat); chk_res("d_2p0",  0, lat, 12, 16'h016A, 17'h0001C, 1'b0);
      run_op(0, 16'hFFFF, 1'b0, lat); chk_res("d_max",  0, lat, 12, 16'h0FFF, 17'h01EFF, 1'b0);
      run_op(0, 16'h8000, 1'b0, lat); chk_res("d_msb",  0, lat, 12, 16'h0B50, 17'h00700, 1'b0);
      run_op(0, 16'h0001, 1'b0, lat); chk_res("d_lsb",  0, lat, 12, 16'h0010, 17'h00000, 1'b0);
      run_op(0, 16'h0000, 1'b0, lat); chk_res("d_zero", 0, lat, 1,  16'h0000, 17'h00000, 1'b0);

      // Back-pressure: result holds for 5 cycles, then hands off.
      d_if.out_ready = 1'b0;
      run_op(0, 16'h0200, 1'b0, lat);
      chk("stall_lat", lat, 12);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_ov",   d_if.out_valid, 1'b1);
         chk("stall_root", d_if.root, 16'h016A);
         chk("stall_rem",  d_if.rem, 17'h0001C);
         chk("stall_err",  d_if.err, 1'b0);
         chk("stall_busy", d_if.in_ready, 1'b0);
      end
      d_if.out_ready = 1'b1;
      step();
      chk("stall_drop",  d_if.out_valid, 1'b0);
      chk("stall_ready", d_if.in_ready, 1'b1);

      // Abort in DONE is ignored.
      d_if.out_ready = 1'b0;
      run_op(0, 16'h0001, 1'b0, lat);
      chk("abdone_lat", lat, 12);
      d_if.abort = 1'b1;
      step();
      d_if.abort = 1'b0;
      chk("abdone_ov",   d_if.out_valid, 1'b1);
      chk("abdone_root", d_if.root, 16'h0010);
      d_if.out_ready = 1'b1;
      step();
      chk("abdone_drop", d_if.out_valid, 1'b0);

      // Abort together with in_valid in IDLE still accepts the radicand.
      run_op(0, 16'h0400, 1'b1, lat); chk_res("abidle", 0, lat, 12, 16'h0200, 17'h00000, 1'b0);

      // Abort sampled at edge 5 of a run.
      d_if.in_valid = 1'b1;
      d_if.rad = 16'h0400;
      step();
      d_if.in_valid = 1'b0;
      repeat (4) step();
      d_if.abort = 1'b1;
      step();
      d_if.abort = 1'b0;
      chk("abort_ov",    d_if.out_valid, 1'b0);
      chk("abort_ready", d_if.in_ready, 1'b1);
      expect_silence("abort_silent");

      // Reset in the middle of a run.
      d_if.in_valid = 1'b1;
      d_if.rad = 16'hFFFF;
      step();
      d_if.in_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      #1;
      chk("rstrun_ov",    d_if.out_valid, 1'b0);
      chk("rstrun_ready", d_if.in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("rstrun_ready2", d_if.in_ready, 1'b1);
      expect_silence("rstrun_silent");

      // Reset while a result is waiting in DONE.
      d_if.out_ready = 1'b0;
      run_op(0, 16'hFFFF, 1'b0, lat);
      chk("rstdone_lat",  lat, 12);
      chk("rstdone_root", d_if.root, 16'h0FFF);
      rst = 1'b1;
      #1;
      chk("rstdone_ov",    d_if.out_valid, 1'b0);
      chk("rstdone_root0", d_if.root, 16'h0);
      chk("rstdone_rem0",  d_if.rem, 17'h0);
      @(negedge clk);
      rst = 1'b0;
      d_if.out_ready = 1'b1;
      step();
      chk("rstdone_ready", d_if.in_ready, 1'b1);
      expect_silence("rstdone_silent");
      run_op(0, 16'h0400, 1'b0, lat); chk_res("post_rst", 0, lat, 12, 16'h0200, 17'h00000, 1'b0);

      // Two bits per cycle.
      run_op(1, 16'h0200, 1'b0, lat); chk_res("b2_2p0", 1, lat, 6, 16'h016A, 17'h0001C, 1'b0);
      run_op(1, 16'hFFFF, 1'b0, lat); chk_res("b2_max", 1, lat, 6, 16'h0FFF, 17'h01EFF, 1'b0);

      // Signed radicand.
      run_op(2, 16'hFFFF, 1'b0, lat); chk_res("sg_neg1", 2, lat, 1,  16'h0000, 17'h00000, 1'b1);
      run_op(2, 16'h8000, 1'b0, lat); chk_res("sg_min",  2, lat, 1,  16'h0000, 17'h00000, 1'b1);
      run_op(2, 16'h0000, 1'b0, lat); chk_res("sg_zero", 2, lat, 1,  16'h0000, 17'h00000, 1'b0);
      run_op(2, 16'h0400, 1'b0, lat); chk_res("sg_pos",  2, lat, 12, 16'h0200, 17'h00000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
